// File: rtl/sync_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_detect
// Brief    : 1000BASE-X code-group alignment and synchronization state machine
// Revision : 1.0 - initial release
// ============================================================================
module sync_detect (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic [9:0] rx_code_group,
    input  logic       signal_detect,
    output logic [9:0] sync_code_group,
    output logic       rx_even,
    output logic       sync_status,
    output logic       comma_det
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC    = 4'd0,
        COMMA_DETECT_1  = 4'd1,
        COMMA_DETECT_2  = 4'd2,
        COMMA_DETECT_3  = 4'd3,
        ACQUIRE_SYNC_1  = 4'd4,
        ACQUIRE_SYNC_2  = 4'd5,
        SYNC_ACQUIRED_1 = 4'd6,
        SYNC_ACQUIRED_2 = 4'd7,
        SYNC_ACQUIRED_3 = 4'd8,
        SYNC_ACQUIRED_4 = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rd;
    logic [1:0] r_good_cgs;
    logic [1:0] w_good_cgs_nxt;
    logic       w_force_even;
    logic [3:0] w_ones;
    logic       w_comma;
    logic       w_invalid;
    logic       w_cgbad;
    logic       w_sync_nxt;

    always_comb begin
        w_ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'b000, rx_code_group[i]};
        end
    end

    assign w_comma   = (rx_code_group[9:3] == 7'b0011111) ||
                       (rx_code_group[9:3] == 7'b1100000);
    // r_rd = 1 means RD+; a heavy group needs RD-, a light group needs RD+
    assign w_invalid = (w_ones < 4'd4) || (w_ones > 4'd6) ||
                       ((w_ones == 4'd6) && r_rd) ||
                       ((w_ones == 4'd4) && !r_rd);
    assign w_cgbad   = w_invalid || (w_comma && rx_even);

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cgs_nxt = 2'd0;
        w_force_even   = 1'b0;
        case (r_state)
            LOSS_OF_SYNC: begin
                if (w_comma) begin
                    w_state_nxt  = COMMA_DETECT_1;
                    w_force_even = 1'b1;
                end
            end
            COMMA_DETECT_1: w_state_nxt = (!w_invalid && !w_comma) ? ACQUIRE_SYNC_1  : LOSS_OF_SYNC;
            COMMA_DETECT_2: w_state_nxt = (!w_invalid && !w_comma) ? ACQUIRE_SYNC_2  : LOSS_OF_SYNC;
            COMMA_DETECT_3: w_state_nxt = (!w_invalid && !w_comma) ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1, ACQUIRE_SYNC_2: begin
                if (w_cgbad) begin
                    w_state_nxt = LOSS_OF_SYNC;
                end else if (w_comma) begin
                    w_state_nxt  = (r_state == ACQUIRE_SYNC_1) ? COMMA_DETECT_2 : COMMA_DETECT_3;
                    w_force_even = 1'b1;
                end
            end
            SYNC_ACQUIRED_1: begin
                if (w_cgbad) begin
                    w_state_nxt = SYNC_ACQUIRED_2;
                end
            end
            SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4: begin
                if (w_cgbad) begin
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_nxt = SYNC_ACQUIRED_3;
                        SYNC_ACQUIRED_3: w_state_nxt = SYNC_ACQUIRED_4;
                        default:         w_state_nxt = LOSS_OF_SYNC;
                    endcase
                end else if (r_good_cgs == 2'd3) begin
                    case (r_state)
                        SYNC_ACQUIRED_2: w_state_nxt = SYNC_ACQUIRED_1;
                        SYNC_ACQUIRED_3: w_state_nxt = SYNC_ACQUIRED_2;
                        default:         w_state_nxt = SYNC_ACQUIRED_3;
                    endcase
                end else begin
                    w_good_cgs_nxt = r_good_cgs + 2'd1;
                end
            end
            default: w_state_nxt = LOSS_OF_SYNC;
        endcase

        if (!signal_detect) begin
            w_state_nxt    = LOSS_OF_SYNC;
            w_good_cgs_nxt = 2'd0;
            w_force_even   = 1'b0;
        end
    end

    assign w_sync_nxt = (w_state_nxt == SYNC_ACQUIRED_1) || (w_state_nxt == SYNC_ACQUIRED_2) ||
                        (w_state_nxt == SYNC_ACQUIRED_3) || (w_state_nxt == SYNC_ACQUIRED_4);

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            r_state         <= LOSS_OF_SYNC;
            r_rd            <= 1'b0;
            r_good_cgs      <= 2'd0;
            rx_even         <= 1'b0;
            sync_status     <= 1'b0;
            comma_det       <= 1'b0;
            sync_code_group <= 10'h000;
        end else begin
            r_state         <= w_state_nxt;
            r_good_cgs      <= w_good_cgs_nxt;
            rx_even         <= w_force_even ? 1'b1 : ~rx_even;
            sync_status     <= w_sync_nxt;
            comma_det       <= w_comma;
            sync_code_group <= rx_code_group;
            if (w_ones > 4'd5) begin
                r_rd <= 1'b1;
            end else if (w_ones < 4'd5) begin
                r_rd <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_detect
// Brief    : directed self-checking bench for sync_detect
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_detect;

    localparam logic [9:0] C_K   = 10'h0FA;
    localparam logic [9:0] C_D   = 10'h245;
    localparam logic [9:0] C_BAD = 10'h3FF;
    localparam logic [9:0] C_NEU = 10'h155;

    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic [9:0] rx_code_group = 10'h000;
    logic       signal_detect = 1'b1;
    logic [9:0] sync_code_group;
    logic       rx_even;
    logic       sync_status;
    logic       comma_det;

    int checks = 0;
    int errors = 0;

    sync_detect dut (
        .GTX_CLK         (GTX_CLK),
        .mr_main_reset   (mr_main_reset),
        .rx_code_group   (rx_code_group),
        .signal_detect   (signal_detect),
        .sync_code_group (sync_code_group),
        .rx_even         (rx_even),
        .sync_status     (sync_status),
        .comma_det       (comma_det)
    );

    always #5 GTX_CLK = ~GTX_CLK;

    task automatic cycle(input logic [9:0] cg, input logic sd);
        rx_code_group = cg;
        signal_detect = sd;
        @(posedge GTX_CLK);
        #1;
    endtask

    task automatic test_reset;
        mr_main_reset = 1'b1;
        cycle(C_BAD, 1'b1);
        cycle(C_K, 1'b1);
        checks++; if (sync_code_group !== 10'h000) begin errors++; $display("FAIL reset_scg got %h exp 000", sync_code_group); end
        checks++; if (comma_det !== 1'b0) begin errors++; $display("FAIL reset_comma got %b exp 0", comma_det); end
        checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL reset_even got %b exp 0", rx_even); end
        checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL reset_sync got %b exp 0", sync_status); end
        mr_main_reset = 1'b0;
    endtask

    task automatic test_comma;
        cycle(10'h305, 1'b1);
        checks++; if (comma_det !== 1'b1) begin errors++; $display("FAIL comma_minus got %b exp 1", comma_det); end
        checks++; if (sync_code_group !== 10'h305) begin errors++; $display("FAIL comma_scg got %h exp 305", sync_code_group); end
        cycle(10'h0F5, 1'b1);
        checks++; if (comma_det !== 1'b0) begin errors++; $display("FAIL comma_near got %b exp 0", comma_det); end
        cycle(C_K, 1'b1);
        checks++; if (comma_det !== 1'b1) begin errors++; $display("FAIL comma_plus got %b exp 1", comma_det); end
        mr_main_reset = 1'b1;
        cycle(10'h000, 1'b1);
        mr_main_reset = 1'b0;
    endtask

    // Six /I2/ samples from LOSS_OF_SYNC: C1, AS1, C2, AS2, C3, SA1
    task automatic test_reacquire(input string tag);
        logic [9:0] cg;
        logic       exp_bit;
        for (int i = 0; i < 6; i++) begin
            cg = (i % 2 == 0) ? C_K : C_D;
            cycle(cg, 1'b1);
            exp_bit = (i == 5);
            checks++; if (sync_status !== exp_bit) begin errors++; $display("FAIL %s_sync[%0d] got %b exp %b", tag, i, sync_status, exp_bit); end
            exp_bit = (i % 2 == 0);
            checks++; if (rx_even !== exp_bit) begin errors++; $display("FAIL %s_even[%0d] got %b exp %b", tag, i, rx_even, exp_bit); end
            checks++; if (sync_code_group !== cg) begin errors++; $display("FAIL %s_scg[%0d] got %h exp %h", tag, i, sync_code_group, cg); end
        end
    endtask

    task automatic test_single_error;
        cycle(C_BAD, 1'b1);
        checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL single_err_sync got %b exp 1", sync_status); end
        checks++; if (comma_det !== 1'b0) begin errors++; $display("FAIL single_err_comma got %b exp 0", comma_det); end
        for (int i = 0; i < 2; i++) begin
            cycle(C_D, 1'b1);
            cycle(C_K, 1'b1);
            checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL single_good_sync[%0d] got %b exp 1", i, sync_status); end
        end
        // Back in SA1: three spaced errors only reach SA4
        for (int i = 0; i < 3; i++) begin
            cycle(C_D, 1'b1);
            cycle(C_BAD, 1'b1);
            checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL single_sa1_sync[%0d] got %b exp 1", i, sync_status); end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(C_D, 1'b1);
            cycle(C_K, 1'b1);
        end
        checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL single_recover_sync got %b exp 1", sync_status); end
    endtask

    task automatic test_loss;
        logic exp_bit;
        for (int j = 0; j < 4; j++) begin
            cycle(C_D, 1'b1);
            checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL loss_good_sync[%0d] got %b exp 1", j, sync_status); end
            cycle(C_BAD, 1'b1);
            exp_bit = (j != 3);
            checks++; if (sync_status !== exp_bit) begin errors++; $display("FAIL loss_bad_sync[%0d] got %b exp %b", j, sync_status, exp_bit); end
        end
        cycle(C_D, 1'b1);
        checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL loss_hold_sync got %b exp 0", sync_status); end
        test_reacquire("loss_reacq");
    endtask

    task automatic test_misalign;
        logic [9:0] seq [6];
        logic       exp_bit;
        seq = '{C_D, C_K, C_D, C_K, C_D, C_K};
        for (int i = 0; i < 6; i++) begin
            cycle(seq[i], 1'b1);
            exp_bit = (i != 5);
            checks++; if (sync_status !== exp_bit) begin errors++; $display("FAIL misalign_sync[%0d] got %b exp %b", i, sync_status, exp_bit); end
            if (i == 1) begin
                checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL misalign_even got %b exp 0", rx_even); end
            end
        end
        test_reacquire("realign");
    endtask

    task automatic test_signal_detect;
        cycle(C_K, 1'b0);
        checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL sd_drop_sync got %b exp 0", sync_status); end
        cycle(C_D, 1'b1);
        checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL sd_hold_sync got %b exp 0", sync_status); end
        test_reacquire("sd_reacq");
    endtask

    task automatic test_reset_mid;
        mr_main_reset = 1'b1;
        cycle(C_D, 1'b1);
        mr_main_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle(C_K, 1'b1);
            cycle(C_D, 1'b1);
            checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL mid_acq_sync[%0d] got %b exp 0", i, sync_status); end
        end
        mr_main_reset = 1'b1;
        cycle(C_K, 1'b1);
        checks++; if (sync_code_group !== 10'h000) begin errors++; $display("FAIL mid_scg got %h exp 000", sync_code_group); end
        checks++; if (comma_det !== 1'b0) begin errors++; $display("FAIL mid_comma got %b exp 0", comma_det); end
        checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL mid_even got %b exp 0", rx_even); end
        checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL mid_sync got %b exp 0", sync_status); end
        mr_main_reset = 1'b0;
        test_reacquire("mid_reacq");
    endtask

    // Neutral-disparity data inside ACQUIRE_SYNC_1 must neither abort nor shift RD
    task automatic test_neutral;
        logic [9:0] seq [8];
        logic       exp_bit;
        seq = '{C_K, C_D, C_NEU, C_NEU, C_K, C_D, C_K, C_D};
        mr_main_reset = 1'b1;
        cycle(10'h000, 1'b1);
        mr_main_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(seq[i], 1'b1);
            exp_bit = (i == 7);
            checks++; if (sync_status !== exp_bit) begin errors++; $display("FAIL neutral_sync[%0d] got %b exp %b", i, sync_status, exp_bit); end
        end
    endtask

    initial begin
        test_reset();
        test_comma();
        test_reacquire("acquire");
        test_single_error();
        test_loss();
        test_misalign();
        test_signal_detect();
        test_reset_mid();
        test_neutral();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
